// File: rtl/acc_pkg.sv
// Shared accelerator constants and width helpers.
// Holds no state and adds no latency.
// Has no handshake, so backpressure does not apply.
package acc_pkg;

    localparam int IFM_IN_W  = 512;
    localparam int IFM_OUT_W = 144;

    // Bits needed to hold every value 0..n.
    function automatic int clog2_p1(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) <= n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/gearbox_shifter.sv
// Barrel shifter: places an input beat at bit offset i_amt inside the residue-buffer width.
// Purely combinational, with zero latency.
// Has no handshake, so backpressure does not apply.
module gearbox_shifter #(
    parameter int IN_W  = 512,
    parameter int BUF_W = 656,
    parameter int AMT_W = 10
) (
    input  logic [IN_W-1:0]  i_dat,
    input  logic [AMT_W-1:0] i_amt,
    output logic [BUF_W-1:0] o_dat
);

    logic [BUF_W-1:0] w_stage [0:AMT_W];

    assign w_stage[0] = BUF_W'(i_dat);

    // One log2 stage per amount bit. Stages that shift past the buffer width yield zero.
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        assign w_stage[k+1] = i_amt[k] ? (w_stage[k] << (2**k)) : w_stage[k];
    end

    assign o_dat = w_stage[AMT_W];

endmodule

// File: rtl/ifm_gearbox.sv
// Wide-to-narrow IFM width converter. Residue bits carry across beats, and a frame tail is zero-padded.
// The first chunk is valid the cycle after the first accepted beat.
// Backpressure: s_ready depends only on registered fill/flush and start_conv_pulse, never on ifm_read.
module ifm_gearbox
    import acc_pkg::*;
#(
    parameter int INPUT_WIDTH  = IFM_IN_W,
    parameter int OUTPUT_WIDTH = IFM_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_conv_pulse,
    input  logic [INPUT_WIDTH-1:0]  s_fm,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic [OUTPUT_WIDTH-1:0] parse_out,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    ifm_read
);

    localparam int BUF_W = INPUT_WIDTH + OUTPUT_WIDTH;
    localparam int CNT_W = clog2_p1(BUF_W);
    localparam logic [CNT_W-1:0] C_OW = CNT_W'(OUTPUT_WIDTH);
    localparam logic [CNT_W-1:0] C_IW = CNT_W'(INPUT_WIDTH);

    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_fill;
    logic             r_flush;

    logic             w_has_bits;
    logic             w_full;
    logic             w_fits;
    logic             w_o_fire;
    logic             w_i_fire;
    logic [CNT_W-1:0] w_fill_sh;
    logic [BUF_W-1:0] w_buf_sh;
    logic [BUF_W-1:0] w_ins;
    logic [BUF_W-1:0] w_buf_nxt;
    logic [CNT_W-1:0] w_fill_nxt;

    assign w_has_bits = (r_fill != '0);
    assign w_full     = (r_fill >= C_OW);
    assign w_fits     = (r_fill <= C_OW);

    assign out_valid = w_full | (r_flush & w_has_bits);
    assign out_last  = r_flush & w_fits & w_has_bits;
    assign s_ready   = ~r_flush & w_fits & ~start_conv_pulse;
    assign parse_out = r_buf[OUTPUT_WIDTH-1:0];

    assign w_o_fire = out_valid & ifm_read;
    assign w_i_fire = s_valid & s_ready;

    // Drain first. The incoming beat then lands directly above the surviving residue.
    assign w_fill_sh = w_o_fire ? (w_full ? (r_fill - C_OW) : '0) : r_fill;
    assign w_buf_sh  = w_o_fire ? (r_buf >> OUTPUT_WIDTH) : r_buf;

    gearbox_shifter #(
        .IN_W  (INPUT_WIDTH),
        .BUF_W (BUF_W),
        .AMT_W (CNT_W)
    ) u_shifter (
        .i_dat (s_fm),
        .i_amt (w_fill_sh),
        .o_dat (w_ins)
    );

    assign w_buf_nxt  = w_buf_sh | (w_i_fire ? w_ins : '0);
    assign w_fill_nxt = w_fill_sh + (w_i_fire ? C_IW : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf   <= '0;
            r_fill  <= '0;
            r_flush <= 1'b0;
        end else if (start_conv_pulse) begin
            r_buf   <= '0;
            r_fill  <= '0;
            r_flush <= 1'b0;
        end else begin
            r_buf  <= w_buf_nxt;
            r_fill <= w_fill_nxt;
            // s_ready is low while flushing, so closing and opening a frame cannot coincide.
            if (w_o_fire & out_last) begin
                r_flush <= 1'b0;
            end else if (w_i_fire & s_last) begin
                r_flush <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ifm_gearbox.sv
// Scoreboard bench for ifm_gearbox covering three width pairs (512/144, 8/3, 3/8) behind one shared driver.
// A bit-queue reference model predicts the chunks, and the monitor checks every cycle at the falling edge.
module tb_ifm_gearbox;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [511:0] s_fm;
    logic         s_valid;
    logic         s_last;
    logic         ifm_read;
    logic [1:0]   sel;
    int           cur_iw;
    int           cur_ow;

    logic         a_rdy, a_vld, a_lst;
    logic [143:0] a_dat;
    logic         b_rdy, b_vld, b_lst;
    logic [2:0]   b_dat;
    logic         c_rdy, c_vld, c_lst;
    logic [7:0]   c_dat;

    logic         m_ready, m_valid, m_last;
    logic [511:0] m_dat;

    int checks   = 0;
    int failures = 0;
    int n_pop    = 0;

    logic [511:0] exp_dat[$];
    bit           exp_last[$];
    int           exp_bits[$];
    bit           pend[$];

    ifm_gearbox #(.INPUT_WIDTH(512), .OUTPUT_WIDTH(144)) u_a (
        .clk(clk), .rst_n(rst_n), .start_conv_pulse(start), .s_fm(s_fm),
        .s_valid(s_valid & (sel == 2'd0)), .s_last(s_last), .s_ready(a_rdy),
        .parse_out(a_dat), .out_valid(a_vld), .out_last(a_lst),
        .ifm_read(ifm_read & (sel == 2'd0))
    );

    ifm_gearbox #(.INPUT_WIDTH(8), .OUTPUT_WIDTH(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start_conv_pulse(start), .s_fm(s_fm[7:0]),
        .s_valid(s_valid & (sel == 2'd1)), .s_last(s_last), .s_ready(b_rdy),
        .parse_out(b_dat), .out_valid(b_vld), .out_last(b_lst),
        .ifm_read(ifm_read & (sel == 2'd1))
    );

    ifm_gearbox #(.INPUT_WIDTH(3), .OUTPUT_WIDTH(8)) u_c (
        .clk(clk), .rst_n(rst_n), .start_conv_pulse(start), .s_fm(s_fm[2:0]),
        .s_valid(s_valid & (sel == 2'd2)), .s_last(s_last), .s_ready(c_rdy),
        .parse_out(c_dat), .out_valid(c_vld), .out_last(c_lst),
        .ifm_read(ifm_read & (sel == 2'd2))
    );

    always_comb begin
        m_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_dat   = '0;
        case (sel)
            2'd0: begin m_ready = a_rdy; m_valid = a_vld; m_last = a_lst; m_dat[143:0] = a_dat; end
            2'd1: begin m_ready = b_rdy; m_valid = b_vld; m_last = b_lst; m_dat[2:0]   = b_dat; end
            default: begin m_ready = c_rdy; m_valid = c_vld; m_last = c_lst; m_dat[7:0] = c_dat; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int held_bits();
        int s;
        s = pend.size();
        foreach (exp_bits[i]) s += exp_bits[i];
        return s;
    endfunction

    function automatic bit frame_open();
        bit r;
        r = 1'b0;
        foreach (exp_last[i]) if (exp_last[i]) r = 1'b1;
        return r;
    endfunction

    function automatic logic [511:0] rand_beat(input int iw);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < iw; i++) b[i] = 1'($urandom_range(1));
        return b;
    endfunction

    task automatic model_clear();
        exp_dat.delete();
        exp_last.delete();
        exp_bits.delete();
        pend.delete();
    endtask

    // The frame is one LSB-first bit stream cut into cur_ow pieces, with a short padded tail at s_last.
    task automatic model_accept(input logic [511:0] beat, input bit last);
        logic [511:0] c;
        int n;
        for (int i = 0; i < cur_iw; i++) pend.push_back(beat[i]);
        while (pend.size() >= cur_ow) begin
            c = '0;
            for (int j = 0; j < cur_ow; j++) c[j] = pend.pop_front();
            exp_dat.push_back(c);
            exp_last.push_back(last && (pend.size() == 0));
            exp_bits.push_back(cur_ow);
        end
        if (last && pend.size() > 0) begin
            n = pend.size();
            c = '0;
            for (int j = 0; j < n; j++) c[j] = pend.pop_front();
            exp_dat.push_back(c);
            exp_last.push_back(1'b1);
            exp_bits.push_back(n);
        end
    endtask

    always @(negedge clk) begin
        bit ev;
        if (rst_n) begin
            ev = (exp_dat.size() > 0);
            chk("out_valid", 512'(m_valid), 512'(ev));
            chk("s_ready", 512'(m_ready),
                512'(!start && !frame_open() && (held_bits() <= cur_ow)));
            if (ev) begin
                chk("out_last", 512'(m_last), 512'(exp_last[0]));
                chk("parse_out", m_dat, exp_dat[0]);
                if (m_valid && ifm_read) begin
                    void'(exp_dat.pop_front());
                    void'(exp_last.pop_front());
                    void'(exp_bits.pop_front());
                    n_pop++;
                end
            end
        end
    end

    task automatic set_sel(input logic [1:0] s, input int iw, input int ow);
        sel    = s;
        cur_iw = iw;
        cur_ow = ow;
        @(posedge clk);
        #1;
    endtask

    task automatic do_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 512'(m_valid), 512'(0));
        chk("rst_out_last", 512'(m_last), 512'(0));
        chk("rst_parse_out", m_dat, 512'(0));
        chk("rst_s_ready", 512'(m_ready), 512'(1));
        model_clear();
        s_valid  = 1'b0;
        ifm_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_frame(input int nb, input int rd_pct, input int pulse_at,
                             input int rst_at, input int exp_n);
        logic [511:0] beats[$];
        int  bi;
        int  cyc;
        bit  acc;
        bit  pulsed;
        bit  pchk;
        bit  done;
        bi = 0; cyc = 0; pulsed = 0; pchk = 0; done = 0;
        for (int k = 0; k < nb; k++) beats.push_back(rand_beat(cur_iw));
        n_pop = 0;
        while (!done) begin
            start = 1'b0;
            if (!pulsed && pulse_at >= 0 && n_pop >= pulse_at) begin
                start    = 1'b1;
                pulsed   = 1'b1;
                pchk     = 1'b1;
                ifm_read = 1'b0;
            end else begin
                ifm_read = ($urandom_range(99) < rd_pct);
            end
            s_valid = (bi < nb);
            s_fm    = (bi < nb) ? beats[bi] : '0;
            s_last  = (bi == nb - 1);
            @(negedge clk);
            if (pchk && !start) begin
                chk("pulse_out_valid", 512'(m_valid), 512'(0));
                chk("pulse_s_ready", 512'(m_ready), 512'(1));
                pchk = 1'b0;
            end
            acc = s_valid && m_ready;
            if (rst_at >= 0 && n_pop >= rst_at && m_valid) begin
                do_async_reset();
                acc  = 1'b0;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (start) model_clear();
            if (acc) begin
                model_accept(beats[bi], bi == nb - 1);
                bi++;
            end
            cyc++;
            if (bi == nb && exp_dat.size() == 0 && pend.size() == 0) done = 1'b1;
            if (cyc > 3000) begin
                chk("timeout", 512'(cyc), 512'(0));
                done = 1'b1;
            end
        end
        start    = 1'b0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        ifm_read = 1'b0;
        if (rst_at < 0) begin
            @(negedge clk);
            chk("end_out_valid", 512'(m_valid), 512'(0));
            chk("end_s_ready", 512'(m_ready), 512'(1));
            if (exp_n >= 0) chk("chunk_count", 512'(n_pop), 512'(exp_n));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        s_fm     = '0;
        s_valid  = 1'b0;
        s_last   = 1'b0;
        ifm_read = 1'b0;
        sel      = 2'd0;
        cur_iw   = 512;
        cur_ow   = 144;
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("reset_out_valid", 512'(m_valid), 512'(0));
            chk("reset_out_last", 512'(m_last), 512'(0));
            chk("reset_parse_out", m_dat, 512'(0));
            chk("reset_s_ready", 512'(m_ready), 512'(1));
        end
        #14;
        rst_n = 1'b1;

        set_sel(2'd0, 512, 144);
        run_frame(9, 100, -1, -1, 32);
        run_frame(1, 100, -1, -1, 4);
        run_frame(9, 30, -1, -1, 32);
        run_frame(5, 60, -1, -1, 18);
        run_frame(9, 100, 5, -1, -1);
        run_frame(9, 100, -1, 3, -1);
        run_frame(9, 100, -1, -1, 32);

        set_sel(2'd1, 8, 3);
        run_frame(3, 100, -1, -1, 8);
        run_frame(3, 40, -1, -1, 8);
        run_frame(4, 70, -1, -1, 11);

        set_sel(2'd2, 3, 8);
        run_frame(8, 100, -1, -1, 3);
        run_frame(8, 50, -1, -1, 3);
        run_frame(5, 60, -1, -1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
